usat_acc: RTL
=============

USAT_ACC -- requirements
Module: usat_acc

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the sample and accumulator width in bits.
REQ-002 The block SHALL have parameter FRAME_LEN, default 4, giving the number of samples per frame; legal range 1..255.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port in_valid  input  1  the input sample is valid.
REQ-006 The block SHALL have port in_ready  output  1  the block accepts a sample this cycle.
REQ-007 The block SHALL have port in_data  input  DATA_WIDTH  the unsigned sample, normally a saturated adder output.
REQ-008 The block SHALL have port flush  input  1  a request to close the current frame early.
REQ-009 The block SHALL have port out_valid  output  1  a frame result is presented.
REQ-010 The block SHALL have port out_ready  input  1  the consumer takes the result this cycle.
REQ-011 The block SHALL have port out_data  output  DATA_WIDTH  the saturated frame sum.
REQ-012 The block SHALL have port out_count  output  8  the number of samples in the frame.
REQ-013 The block SHALL have port out_sat  output  1  sticky flag: saturation occurred at least once in the frame.
REQ-014 The block SHALL have port out_residual  output  DATA_WIDTH  the summed excess above MAX, itself saturating.

Function
REQ-015 The block SHALL implement two states: ACCUM and HOLD.
REQ-016 In ACCUM, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-017 In ACCUM, on an accept (in_valid and in_ready), the block SHALL update acc, count, sat and residual as follows:
- sum = {0,acc}+{0,in_data}, DATA_WIDTH+1 bits.
- acc <= sum[DATA_WIDTH] ? MAX (all ones) : sum[DATA_WIDTH-1:0].
- count <= count+1.
- sat <= sat | sum[DATA_WIDTH].
REQ-018 On a saturating accept, the excess SHALL be sum-MAX, added to residual with saturation at MAX.
REQ-019 ACCUM->HOLD SHALL occur on the edge at which the accepted sample makes count equal FRAME_LEN; out_valid rises the following cycle (latency 1).
REQ-020 ACCUM->HOLD SHALL also occur on flush=1 when the post-edge count is >=1.
REQ-021 When flush coincides with an accept, the accepted sample SHALL be included in the frame.
REQ-022 A flush with count 0 and no accept SHALL be ignored.
REQ-023 In HOLD, in_ready SHALL be 0, out_valid SHALL be 1, and out_data/out_count/out_sat/out_residual SHALL be held stable until out_ready=1.
REQ-024 HOLD->ACCUM SHALL occur on out_valid and out_ready; acc, count, sat and residual clear to 0 on the same edge.
REQ-025 flush SHALL be ignored in HOLD.
REQ-026 No combinational path SHALL exist from out_ready to in_ready; one idle cycle between frames is required.
REQ-027 acc SHALL never wrap; once at MAX it stays MAX for the rest of the frame.

Reset
REQ-028 On rising clk with rst_n=0, state SHALL become ACCUM and acc, count, sat and residual SHALL become 0.
REQ-029 During reset the outputs SHALL be: out_valid=0, out_data=0, out_count=0, out_sat=0, out_residual=0, in_ready=0.
REQ-030 in_ready SHALL be 1 from the first cycle after rst_n returns to 1.
REQ-031 Reset mid-frame or in HOLD SHALL discard the pending frame with no output handshake.

Configuration
REQ-032 Macro USAT_ACC_RESIDUAL_EN SHALL control the residual logic.
- Defined: the residual register and its logic per REQ-018 are present.
- Undefined: the residual register is absent, out_residual is tied to 0, and all other behaviour is identical.

Verification (DATA_WIDTH=8, FRAME_LEN=4)
REQ-033 Basic frame: accept 10,20,30,40 -> out_data=100, out_count=4, out_sat=0, out_residual=0; out_valid rises one cycle after the 4th accept.
REQ-034 Saturation: accept 200,100,1,1 -> out_data=255, out_sat=1, out_residual=47 with the macro defined and 0 without it.
REQ-035 Backpressure: hold out_ready=0 for 3 cycles in HOLD with in_valid=1.
- Required: outputs stable and in_ready=0 throughout; no sample lost; the next frame starts clean after the handshake.
REQ-036 Flush: accept 5, then 7 together with flush=1 -> out_data=12, out_count=2; a flush at count 0 produces no out_valid.
REQ-037 Reset mid-frame: accept 50,60, assert rst_n=0 for 1 cycle, then accept 1,2,3,4.
- Required: out_data=10, out_count=4.

Source files
------------

// File: rtl/usat_acc.sv
// usat_acc: saturating unsigned frame accumulator with a hold-until-taken result handshake.
// Define USAT_ACC_RESIDUAL_EN to keep the saturating sum of excess above MAX on out_residual.
module usat_acc #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [7:0]            out_count,
  output logic                  out_sat,
  output logic [DATA_WIDTH-1:0] out_residual
);
  typedef enum logic {ACCUM, HOLD} state_t;
  localparam logic [DATA_WIDTH-1:0] MAX = '1;
  localparam logic [7:0] LEN = 8'(FRAME_LEN);
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] acc, acc_nx;
  logic [DATA_WIDTH:0] sum;
  logic [7:0] count, count_nx;
  logic sat, accept, take;
  assign in_ready  = rst_n && state == ACCUM;
  assign out_valid = state == HOLD;
  assign out_data  = acc;
  assign out_count = count;
  assign out_sat   = sat;
  always_comb begin
    accept   = in_valid && in_ready;
    take     = out_valid && out_ready;
    sum      = {1'b0, acc} + {1'b0, in_data};
    acc_nx   = sum[DATA_WIDTH] ? MAX : sum[DATA_WIDTH-1:0];
    count_nx = count + 8'(accept);
    state_nx = state;
    if (state == ACCUM)
      state_nx = ((accept && count_nx == LEN) || (flush && count_nx != 8'd0)) ? HOLD : ACCUM;
    else
      state_nx = take ? ACCUM : HOLD;
  end
  always_ff @(posedge clk)
    state <= !rst_n ? ACCUM : state_nx;
  always_ff @(posedge clk) begin
    if (!rst_n || take) begin
      acc   <= '0;
      count <= '0;
      sat   <= 1'b0;
    end else if (accept) begin
      acc   <= acc_nx;
      count <= count_nx;
      sat   <= sat | sum[DATA_WIDTH];
    end
  end
`ifdef USAT_ACC_RESIDUAL_EN
  logic [DATA_WIDTH-1:0] residual, excess;
  logic [DATA_WIDTH:0] rsum;
  // sum - MAX equals the low bits plus one whenever the carry is set
  always_comb begin
    excess = sum[DATA_WIDTH-1:0] + DATA_WIDTH'(1);
    rsum   = {1'b0, residual} + {1'b0, excess};
  end
  always_ff @(posedge clk) begin
    if (!rst_n || take)
      residual <= '0;
    else if (accept && sum[DATA_WIDTH])
      residual <= rsum[DATA_WIDTH] ? MAX : rsum[DATA_WIDTH-1:0];
  end
  assign out_residual = residual;
`else
  assign out_residual = '0;
`endif
endmodule
